// File: rtl/div_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : div_issue_ctrl
// Description : Issue/response controller for the RV32IM DIV/DIVU/REM/REMU
//               operations. Latches a request, handles the RISC-V division
//               corner cases locally, and otherwise drives the external
//               combinational signed divider. The result is held in a response
//               register until writeback accepts it.
//               Optional macro DIVU_SEQ_EN adds an internal restoring divider
//               for unsigned operands with an MSB set. The signed external
//               divider cannot handle those operands.
// Revision    : 1.0 - initial release
// ============================================================================
module div_issue_ctrl #(
    parameter int LENGTH  = 32,
    parameter int TIMEOUT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [2:0]        funct3_i,
    input  logic [LENGTH-1:0] rs1_i,
    input  logic [LENGTH-1:0] rs2_i,
    input  logic [4:0]        rd_i,
    output logic [LENGTH-1:0] oper_a_o,
    output logic [LENGTH-1:0] oper_b_o,
    output logic              fuct3_o,
    output logic              enable_div_o,
    input  logic              divided_by_zero_i,
    input  logic [LENGTH-1:0] div_o_i,
    input  logic              div_finish_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [LENGTH-1:0] rsp_data_o,
    output logic [4:0]        rsp_rd_o,
    output logic              rsp_err_o,
    output logic              busy_o
);

    localparam int                WAIT_W  = $clog2(TIMEOUT + 1);
    localparam logic [LENGTH-1:0] MIN_NEG = {1'b1, {(LENGTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_SEQ  = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          funct3_q, funct3_d;   // [1]=remainder, [0]=unsigned
    logic [LENGTH-1:0]   a_q, a_d;
    logic [LENGTH-1:0]   b_q, b_d;
    logic [4:0]          rd_q, rd_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [LENGTH-1:0]   data_q, data_d;
    logic                err_q, err_d;
    logic                w_signed_in;

    assign w_signed_in = ~funct3_i[0];

`ifdef DIVU_SEQ_EN
    localparam int CNT_W = $clog2(LENGTH);

    logic [LENGTH-1:0]   rem_q, rem_d;
    logic [LENGTH-1:0]   quot_q, quot_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                init_q, init_d;
    logic [LENGTH:0]     w_shift;
    logic                w_ge;
    logic [LENGTH-1:0]   w_rem_next;
    logic [LENGTH-1:0]   w_quot_next;

    // One restoring step: shift in the next dividend bit, subtract if it fits
    always_comb begin
        w_shift     = {rem_q, quot_q[LENGTH-1]};
        w_ge        = (w_shift >= {1'b0, b_q});
        w_rem_next  = w_ge ? LENGTH'(w_shift - {1'b0, b_q}) : w_shift[LENGTH-1:0];
        w_quot_next = {quot_q[LENGTH-2:0], w_ge};
    end
`endif

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            funct3_q <= '0;
            a_q      <= '0;
            b_q      <= '0;
            rd_q     <= '0;
            wait_q   <= '0;
            data_q   <= '0;
            err_q    <= 1'b0;
`ifdef DIVU_SEQ_EN
            rem_q    <= '0;
            quot_q   <= '0;
            cnt_q    <= '0;
            init_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            funct3_q <= funct3_d;
            a_q      <= a_d;
            b_q      <= b_d;
            rd_q     <= rd_d;
            wait_q   <= wait_d;
            data_q   <= data_d;
            err_q    <= err_d;
`ifdef DIVU_SEQ_EN
            rem_q    <= rem_d;
            quot_q   <= quot_d;
            cnt_q    <= cnt_d;
            init_q   <= init_d;
`endif
        end
    end

    // Next-state logic: request decode, corner-case bypass, divider supervision
    always_comb begin
        state_d  = state_q;
        funct3_d = funct3_q;
        a_d      = a_q;
        b_d      = b_q;
        rd_d     = rd_q;
        wait_d   = wait_q;
        data_d   = data_q;
        err_d    = err_q;
`ifdef DIVU_SEQ_EN
        rem_d    = rem_q;
        quot_d   = quot_q;
        cnt_d    = cnt_q;
        init_d   = init_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    funct3_d = funct3_i[1:0];
                    a_d      = rs1_i;
                    b_d      = rs2_i;
                    rd_d     = rd_i;
                    wait_d   = '0;
                    data_d   = '0;
                    err_d    = 1'b0;
                    state_d  = S_RESP;
                    if (!funct3_i[2]) begin
                        // Not an M-extension divide encoding
                        err_d = 1'b1;
                    end else if (rs2_i == '0) begin
                        data_d = funct3_i[1] ? rs1_i : '1;
                    end else if (w_signed_in && (rs1_i == MIN_NEG) && (rs2_i == '1)) begin
                        data_d = funct3_i[1] ? '0 : MIN_NEG;
                    end else if (w_signed_in || (!rs1_i[LENGTH-1] && !rs2_i[LENGTH-1])) begin
                        state_d = S_EXEC;
                    end else begin
`ifdef DIVU_SEQ_EN
                        state_d = S_SEQ;
                        init_d  = 1'b1;
`else
                        // Signed divider cannot represent these unsigned operands
                        err_d = 1'b1;
`endif
                    end
                end
            end
            S_EXEC: begin
                if (divided_by_zero_i) begin
                    // Zero divisors never reach the divider, so this is a fault
                    data_d  = '0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else if (div_finish_i) begin
                    data_d  = div_o_i;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
                    data_d  = '0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
`ifdef DIVU_SEQ_EN
            S_SEQ: begin
                if (init_q) begin
                    rem_d  = '0;
                    quot_d = a_q;
                    cnt_d  = '0;
                    init_d = 1'b0;
                end else begin
                    rem_d  = w_rem_next;
                    quot_d = w_quot_next;
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (cnt_q == '1) begin
                        data_d  = funct3_q[1] ? w_rem_next : w_quot_next;
                        err_d   = 1'b0;
                        state_d = S_RESP;
                    end
                end
            end
`endif
            S_RESP: begin
                if (rsp_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign req_ready_o  = (state_q == S_IDLE);
    assign busy_o       = (state_q != S_IDLE);
    assign enable_div_o = (state_q == S_EXEC);
    assign oper_a_o     = enable_div_o ? a_q : '0;
    assign oper_b_o     = enable_div_o ? b_q : '0;
    assign fuct3_o      = enable_div_o & ~funct3_q[1];
    assign rsp_valid_o  = (state_q == S_RESP);
    assign rsp_data_o   = data_q;
    assign rsp_rd_o     = rd_q;
    assign rsp_err_o    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_div_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_issue_ctrl
// Description : Directed self-checking bench for div_issue_ctrl with a
//               behavioural combinational signed divider.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  funct3 = '0;
    logic [31:0] rs1 = '0;
    logic [31:0] rs2 = '0;
    logic [4:0]  rd = '0;
    logic [31:0] oper_a, oper_b;
    logic        fuct3, enable_div;
    logic        dbz;
    logic [31:0] div_res;
    logic        div_finish;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic [4:0]  rsp_rd;
    logic        rsp_err;
    logic        busy;
    logic        finish_en = 1'b1;

    int n_checks = 0;
    int n_errors = 0;

    div_issue_ctrl #(.LENGTH(32), .TIMEOUT(4)) u_dut (
        .clk               (clk),
        .rst               (rst),
        .req_valid_i       (req_valid),
        .req_ready_o       (req_ready),
        .funct3_i          (funct3),
        .rs1_i             (rs1),
        .rs2_i             (rs2),
        .rd_i              (rd),
        .oper_a_o          (oper_a),
        .oper_b_o          (oper_b),
        .fuct3_o           (fuct3),
        .enable_div_o      (enable_div),
        .divided_by_zero_i (dbz),
        .div_o_i           (div_res),
        .div_finish_i      (div_finish),
        .rsp_valid_o       (rsp_valid),
        .rsp_ready_i       (rsp_ready),
        .rsp_data_o        (rsp_data),
        .rsp_rd_o          (rsp_rd),
        .rsp_err_o         (rsp_err),
        .busy_o            (busy)
    );

    always #5 clk = ~clk;

    // Behavioural combinational signed divider
    always_comb begin
        div_res    = '0;
        dbz        = 1'b0;
        div_finish = 1'b0;
        if (enable_div) begin
            div_finish = finish_en;
            dbz        = (oper_b == '0);
            if (oper_b != '0) begin
                div_res = fuct3 ? 32'($signed(oper_a) / $signed(oper_b))
                                : 32'($signed(oper_a) % $signed(oper_b));
            end
        end
    end

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request and return one cycle after the accepting edge
    task automatic do_req(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] tag);
        int n = 0;
        req_valid = 1'b1;
        funct3    = f3;
        rs1       = a;
        rs2       = b;
        rd        = tag;
        while (!req_ready && n < 50) begin
            tick();
            n++;
        end
        check_value("req_ready_wait", {31'b0, req_ready}, 32'd1);
        tick();
        req_valid = 1'b0;
    endtask

    // Check a visible response, then let writeback take it
    task automatic take_resp(input string tag, input logic [31:0] exp_data, input logic exp_err,
                             input logic [4:0] exp_rd);
        check_value({tag, "_valid"}, {31'b0, rsp_valid}, 32'd1);
        check_value({tag, "_data"}, rsp_data, exp_data);
        check_value({tag, "_err"}, {31'b0, rsp_err}, {31'b0, exp_err});
        check_value({tag, "_rd"}, {27'b0, rsp_rd}, {27'b0, exp_rd});
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check_value({tag, "_drop"}, {31'b0, rsp_valid}, 32'd0);
    endtask

    initial begin
        #12;
        // Reset state
        check_value("rst_ready", {31'b0, req_ready}, 32'd1);
        check_value("rst_busy", {31'b0, busy}, 32'd0);
        check_value("rst_valid", {31'b0, rsp_valid}, 32'd0);
        check_value("rst_enable", {31'b0, enable_div}, 32'd0);
        check_value("rst_data", rsp_data, 32'd0);
        rst = 1'b0;
        tick();

        // DIV -20/3 through the external divider
        do_req(3'b100, 32'hFFFF_FFEC, 32'd3, 5'd5);
        check_value("div_en", {31'b0, enable_div}, 32'd1);
        check_value("div_opa", oper_a, 32'hFFFF_FFEC);
        check_value("div_opb", oper_b, 32'd3);
        check_value("div_fuct3", {31'b0, fuct3}, 32'd1);
        check_value("div_busy", {31'b0, busy}, 32'd1);
        check_value("div_early", {31'b0, rsp_valid}, 32'd0);
        tick();
        check_value("div_en_off", {31'b0, enable_div}, 32'd0);
        check_value("div_opa_off", oper_a, 32'd0);
        take_resp("div_neg", 32'hFFFF_FFFA, 1'b0, 5'd5);

        // REM 7/0 and DIVU 7/0 bypass
        do_req(3'b110, 32'd7, 32'd0, 5'd3);
        check_value("rem0_en", {31'b0, enable_div}, 32'd0);
        take_resp("rem0", 32'd7, 1'b0, 5'd3);
        do_req(3'b101, 32'd7, 32'd0, 5'd4);
        take_resp("divu0", 32'hFFFF_FFFF, 1'b0, 5'd4);

        // Signed overflow bypass
        do_req(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6);
        check_value("ovf_en", {31'b0, enable_div}, 32'd0);
        take_resp("div_ovf", 32'h8000_0000, 1'b0, 5'd6);
        do_req(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7);
        take_resp("rem_ovf", 32'd0, 1'b0, 5'd7);

        // Unsupported funct3 encoding
        do_req(3'b000, 32'd9, 32'd2, 5'd8);
        take_resp("bad_f3", 32'd0, 1'b1, 5'd8);

        // DIVU / REMU with MSB set
`ifdef DIVU_SEQ_EN
        do_req(3'b101, 32'hFFFF_FFFE, 32'd3, 5'd9);
        for (int i = 0; i < 32; i++) tick();
        check_value("seq_early", {31'b0, rsp_valid}, 32'd0);
        check_value("seq_en", {31'b0, enable_div}, 32'd0);
        tick();
        take_resp("divu_seq", 32'h5555_5554, 1'b0, 5'd9);
        do_req(3'b111, 32'hFFFF_FFFE, 32'd3, 5'd10);
        for (int i = 0; i < 33; i++) tick();
        take_resp("remu_seq", 32'd2, 1'b0, 5'd10);
`else
        do_req(3'b101, 32'hFFFF_FFFE, 32'd3, 5'd9);
        check_value("divu_msb_en", {31'b0, enable_div}, 32'd0);
        take_resp("divu_msb", 32'd0, 1'b1, 5'd9);
        do_req(3'b111, 32'hFFFF_FFFE, 32'd3, 5'd10);
        take_resp("remu_msb", 32'd0, 1'b1, 5'd10);
`endif

        // Divider never finishes: timeout after 4 EXEC cycles
        finish_en = 1'b0;
        do_req(3'b100, 32'd100, 32'd7, 5'd11);
        for (int i = 0; i < 4; i++) begin
            check_value("to_en", {31'b0, enable_div}, 32'd1);
            check_value("to_nvalid", {31'b0, rsp_valid}, 32'd0);
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            check_value("hold_valid", {31'b0, rsp_valid}, 32'd1);
            check_value("hold_data", rsp_data, 32'd0);
            check_value("hold_err", {31'b0, rsp_err}, 32'd1);
            check_value("hold_ready", {31'b0, req_ready}, 32'd0);
            tick();
        end
        take_resp("timeout", 32'd0, 1'b1, 5'd11);

        // Reset during EXEC
        do_req(3'b100, 32'd100, 32'd7, 5'd12);
        check_value("rx_en_pre", {31'b0, enable_div}, 32'd1);
        rst = 1'b1;
        #1;
        check_value("rx_en", {31'b0, enable_div}, 32'd0);
        check_value("rx_opa", oper_a, 32'd0);
        check_value("rx_ready", {31'b0, req_ready}, 32'd1);
        check_value("rx_busy", {31'b0, busy}, 32'd0);
        rst = 1'b0;
        tick();
        check_value("rx_norsp", {31'b0, rsp_valid}, 32'd0);

        // Reset during RESP
        finish_en = 1'b1;
        do_req(3'b110, 32'd7, 32'd0, 5'd13);
        check_value("rr_valid_pre", {31'b0, rsp_valid}, 32'd1);
        rst = 1'b1;
        #1;
        check_value("rr_valid", {31'b0, rsp_valid}, 32'd0);
        check_value("rr_data", rsp_data, 32'd0);
        check_value("rr_rd", {27'b0, rsp_rd}, 32'd0);
        check_value("rr_ready", {31'b0, req_ready}, 32'd1);
        rst = 1'b0;
        tick();
        check_value("rr_norsp", {31'b0, rsp_valid}, 32'd0);

        // Normal operation after reset
        do_req(3'b100, 32'd100, 32'd7, 5'd14);
        tick();
        take_resp("post_rst", 32'd14, 1'b0, 5'd14);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
